// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU responder and its reference model:
//   - alu_op_e      : operation select encoding (ADD, SUB, AND, OR)
//   - DEFAULT_*     : default operand / select widths
//   - ALU_MAX_WIDTH : widest operand alu_compute accepts
//   - alu_compute   : combinational result of one operation, one bit wider
//                     than the operands
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_SEL_WIDTH  = 2;

    // alu_compute works at this width. Callers zero-extend their operands and
    // truncate the result to DATA_WIDTH+1. Truncating the wide subtraction
    // gives the same value as subtracting modulo 2^(DATA_WIDTH+1).
    localparam int ALU_MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_e;

    function automatic logic [ALU_MAX_WIDTH:0] alu_compute(
        input logic [ALU_MAX_WIDTH-1:0] a,
        input logic [ALU_MAX_WIDTH-1:0] b,
        input alu_op_e                  op
    );
        logic [ALU_MAX_WIDTH:0] res;
        // NOTE: assign a default before the case so every path drives the
        // result; in always_comb a missing path would infer a latch.
        res = '0;
        case (op)
            ALU_ADD: res = {1'b0, a} + {1'b0, b};
            ALU_SUB: res = {1'b0, a} - {1'b0, b};
            ALU_AND: res = {1'b0, a & b};
            ALU_OR:  res = {1'b0, a | b};
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/alu_op_counter.sv
// ---------------------------------------------------------------------------
// alu_op_counter
// Saturating event counter used for the per-operation statistics.
// Clear has priority over increment; the count sticks at all-ones.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset, zeroes the count
//   inc    : count one event this cycle
//   clr    : zero the count (wins over inc)
//   count  : current count
// ---------------------------------------------------------------------------
module alu_op_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/alu_core.sv
// ---------------------------------------------------------------------------
// alu_core
// Two-stage pipelined ALU responder. An operation sampled with valid_i in
// cycle N returns its DATA_WIDTH+1 bit result with a one-cycle valid_o pulse
// in cycle N+2. One operation per cycle, no back-pressure, results in order.
//
// Optional feature, macro ALU_STATS_EN: adds per-operation saturating
// acceptance counters (CNT_WIDTH bits) and their clear input. Without the
// macro those ports, the CNT_WIDTH parameter and the counters are absent.
//
// Ports:
//   clk          : clock, rising edge
//   rst_n        : synchronous active-low reset, drops in-flight operations
//   valid_i      : operation request, sampled every cycle
//   data_i_1     : operand A
//   data_i_2     : operand B
//   sel_i        : operation select (alu_op_e encoding)
//   valid_o      : result valid pulse
//   data_o       : result, held between pulses
//   clr_stats_i  : zero all counters            (ALU_STATS_EN)
//   cnt_*_o      : accepted ADD/SUB/AND/OR ops  (ALU_STATS_EN)
// ---------------------------------------------------------------------------
module alu_core
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int SEL_WIDTH  = DEFAULT_SEL_WIDTH
`ifdef ALU_STATS_EN
    ,
    parameter int CNT_WIDTH  = 16
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] data_i_1,
    input  logic [DATA_WIDTH-1:0] data_i_2,
    input  logic [SEL_WIDTH-1:0]  sel_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH:0]   data_o
`ifdef ALU_STATS_EN
    ,
    input  logic                  clr_stats_i,
    output logic [CNT_WIDTH-1:0]  cnt_add_o,
    output logic [CNT_WIDTH-1:0]  cnt_sub_o,
    output logic [CNT_WIDTH-1:0]  cnt_and_o,
    output logic [CNT_WIDTH-1:0]  cnt_or_o
`endif
);

    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_a;
    logic [DATA_WIDTH-1:0] s1_b;
    logic [SEL_WIDTH-1:0]  s1_sel;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would let stage 2 see the
    // operands stage 1 is loading in the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_sel   <= '0;
            valid_o  <= 1'b0;
            data_o   <= '0;
        end else begin
            // Stage 1: capture the request; operands hold when idle.
            s1_valid <= valid_i;
            if (valid_i) begin
                s1_a   <= data_i_1;
                s1_b   <= data_i_2;
                s1_sel <= sel_i;
            end

            // Stage 2: compute and present; data_o holds when idle.
            valid_o <= s1_valid;
            if (s1_valid) begin
                data_o <= (DATA_WIDTH+1)'(alu_compute(ALU_MAX_WIDTH'(s1_a),
                                                      ALU_MAX_WIDTH'(s1_b),
                                                      alu_op_e'(s1_sel)));
            end
        end
    end

`ifdef ALU_STATS_EN
    // Counting happens at stage-1 acceptance, i.e. on the sampling edge.
    alu_op_e in_op;
    assign in_op = alu_op_e'(sel_i);

    alu_op_counter #(.WIDTH(CNT_WIDTH)) u_cnt_add (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (valid_i && (in_op == ALU_ADD)),
        .clr   (clr_stats_i),
        .count (cnt_add_o)
    );

    alu_op_counter #(.WIDTH(CNT_WIDTH)) u_cnt_sub (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (valid_i && (in_op == ALU_SUB)),
        .clr   (clr_stats_i),
        .count (cnt_sub_o)
    );

    alu_op_counter #(.WIDTH(CNT_WIDTH)) u_cnt_and (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (valid_i && (in_op == ALU_AND)),
        .clr   (clr_stats_i),
        .count (cnt_and_o)
    );

    alu_op_counter #(.WIDTH(CNT_WIDTH)) u_cnt_or (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (valid_i && (in_op == ALU_OR)),
        .clr   (clr_stats_i),
        .count (cnt_or_o)
    );
`endif

endmodule

// File: tb/tb_alu_core.sv
// ---------------------------------------------------------------------------
// tb_alu_core
// Self-checking bench for alu_core with DATA_WIDTH = 8. The driver pushes the
// expected result and the cycle it is due into a queue; a separate monitor
// pops and compares on every valid_o pulse and flags results that never
// arrive. With ALU_STATS_EN defined, the statistics counters are also checked
// (CNT_WIDTH = 4).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_core;

    localparam int DW = 8;
    localparam int SW = 2;
`ifdef ALU_STATS_EN
    localparam int CW = 4;
`endif

    logic          clk;
    logic          rst_n;
    logic          valid_i;
    logic [DW-1:0] data_i_1;
    logic [DW-1:0] data_i_2;
    logic [SW-1:0] sel_i;
    logic          valid_o;
    logic [DW:0]   data_o;
`ifdef ALU_STATS_EN
    logic          clr_stats_i;
    logic [CW-1:0] cnt_add_o;
    logic [CW-1:0] cnt_sub_o;
    logic [CW-1:0] cnt_and_o;
    logic [CW-1:0] cnt_or_o;
`endif

    alu_core #(
        .DATA_WIDTH (DW),
        .SEL_WIDTH  (SW)
`ifdef ALU_STATS_EN
        ,
        .CNT_WIDTH  (CW)
`endif
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid_i     (valid_i),
        .data_i_1    (data_i_1),
        .data_i_2    (data_i_2),
        .sel_i       (sel_i),
        .valid_o     (valid_o),
        .data_o      (data_o)
`ifdef ALU_STATS_EN
        ,
        .clr_stats_i (clr_stats_i),
        .cnt_add_o   (cnt_add_o),
        .cnt_sub_o   (cnt_sub_o),
        .cnt_and_o   (cnt_and_o),
        .cnt_or_o    (cnt_or_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising edges seen so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [DW:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model straight from the operation table, using plain integers.
    function automatic logic [DW:0] ref_model(input int op, input int a, input int b);
        int r;
        case (op)
            0:       r = a + b;
            1:       r = (a - b + 512) % 512;
            2:       r = a & b;
            default: r = a | b;
        endcase
        return r[DW:0];
    endfunction

    // Monitor: results must appear exactly on their due cycle, in order.
    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
            check("missing_result", {31'd0, valid_o}, 32'd1);
            void'(exp_q.pop_front());
        end
        if (valid_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result_cycle", cyc, e.due);
                check("result_data", {23'd0, data_o}, {23'd0, e.data});
            end
        end
    end

    // Drive one operation on the next falling edge; optionally expect it.
    task automatic drive_op(input int op, input int a, input int b, input bit expect_it);
        @(negedge clk);
        valid_i  = 1'b1;
        sel_i    = SW'(op);
        data_i_1 = DW'(a);
        data_i_2 = DW'(b);
        if (expect_it && rst_n) begin
            exp_t e;
            e.due  = cyc + 2;
            e.data = ref_model(op, a, b);
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            valid_i  = 1'b0;
            sel_i    = SW'($urandom_range(0, 3));
            data_i_1 = DW'($urandom_range(0, 255));
            data_i_2 = DW'($urandom_range(0, 255));
`ifdef ALU_STATS_EN
            clr_stats_i = 1'b0;
`endif
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        valid_i  = 1'b1;
        sel_i    = '0;
        data_i_1 = 8'hAA;
        data_i_2 = 8'h55;
`ifdef ALU_STATS_EN
        clr_stats_i = 1'b0;
`endif

        // Reset state, with valid_i asserted to show it is ignored.
        repeat (3) @(negedge clk);
        check("reset_valid_o", {31'd0, valid_o}, 32'd0);
        check("reset_data_o", {23'd0, data_o}, 32'd0);
`ifdef ALU_STATS_EN
        check("reset_cnt_add", {28'd0, cnt_add_o}, 32'd0);
`endif

        // First op on the first edge out of reset: ADD with carry.
        @(negedge clk);
        rst_n    = 1'b1;
        valid_i  = 1'b1;
        sel_i    = 2'b00;
        data_i_1 = 8'd200;
        data_i_2 = 8'd100;
        begin
            exp_t e;
            e.due  = cyc + 2;
            e.data = 9'h12C;
            exp_q.push_back(e);
        end

        // SUB borrow then SUB zero, back-to-back.
        drive_op(1, 5, 10, 1'b1);
        drive_op(1, 7, 7, 1'b1);
        // Logic ops, then idle: data_o must hold the OR result.
        drive_op(2, 8'hF0, 8'h3C, 1'b1);
        drive_op(3, 8'hF0, 8'h0F, 1'b1);
        idle(4);
        check("hold_data_o", {23'd0, data_o}, 32'h0FF);
        check("hold_valid_o", {31'd0, valid_o}, 32'd0);

        // Boundary: max ADD, SUB max-zero and zero-max.
        drive_op(0, 255, 255, 1'b1);
        drive_op(1, 0, 255, 1'b1);
        drive_op(1, 255, 0, 1'b1);
        idle(1);

        // Stream of 10 back-to-back random ops.
        for (int i = 0; i < 10; i++)
            drive_op($urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 255), 1'b1);

        // Random ops with random gaps.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
            drive_op($urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 255), 1'b1);
        end
        idle(4);

        // Reset mid-flight: ops in N and N+1, reset in N+1; neither returns.
        drive_op(0, 17, 33, 1'b0);
        drive_op(3, 1, 2, 1'b0);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        check("midrst_valid_o", {31'd0, valid_o}, 32'd0);
        check("midrst_data_o", {23'd0, data_o}, 32'd0);
        idle(3);
        check("midrst_data_hold", {23'd0, data_o}, 32'd0);

`ifdef ALU_STATS_EN
        // 20 ADDs saturate the 4-bit counter at 15.
        for (int i = 0; i < 20; i++)
            drive_op(0, $urandom_range(0, 255), $urandom_range(0, 255), 1'b1);
        drive_op(2, 3, 6, 1'b1);
        idle(1);
        check("cnt_add_sat", {28'd0, cnt_add_o}, 32'd15);
        check("cnt_and_one", {28'd0, cnt_and_o}, 32'd1);
        check("cnt_sub_zero", {28'd0, cnt_sub_o}, 32'd0);

        // SUB together with clear: clear wins, op still flows through.
        drive_op(1, 9, 4, 1'b1);
        clr_stats_i = 1'b1;
        idle(1);
        check("clr_cnt_add", {28'd0, cnt_add_o}, 32'd0);
        check("clr_cnt_sub", {28'd0, cnt_sub_o}, 32'd0);
        check("clr_cnt_and", {28'd0, cnt_and_o}, 32'd0);
        check("clr_cnt_or", {28'd0, cnt_or_o}, 32'd0);

        drive_op(1, 4, 9, 1'b1);
        idle(1);
        check("cnt_sub_after_clr", {28'd0, cnt_sub_o}, 32'd1);
`endif

        // Drain: every expected result must have been delivered.
        idle(6);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
